// File: rtl/z2_cycle_fsm.sv
// Zorro II bus-cycle sequencer: strobe synchronisers, cycle phase FSM, merged DTACK_n and data-bus controls.
// Optional forced acknowledge after TIMEOUT_CYCLES in Z2_DATA when DTACK_TIMEOUT_EN is defined.
module z2_cycle_fsm #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       AS_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       RW,
  input  logic       board_sel,
  input  logic       ac_dtack,
  input  logic       dev_ready,
  output logic [1:0] z2_state,
  output logic       DTACK_n,
  output logic       dtack_oe,
  output logic       data_oe_n,
  output logic       data_latch,
  output logic       cycle_timeout
);

  typedef enum logic [1:0] {
    Z2_IDLE  = 2'b00,
    Z2_START = 2'b01,
    Z2_DATA  = 2'b10,
    Z2_END   = 2'b11
  } z2_state_t;

  z2_state_t  state, state_nx;
  logic [1:0] as_sync, uds_sync, lds_sync;
  logic       as_s, ds_s;
  logic       rw_l;
  logic       skip, skip_nx;
  logic       ack;
  logic       tmo_hit, tmo_fire;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      as_sync  <= 2'b11;
      uds_sync <= 2'b11;
      lds_sync <= 2'b11;
    end else begin
      as_sync  <= {as_sync[0], AS_n};
      uds_sync <= {uds_sync[0], UDS_n};
      lds_sync <= {lds_sync[0], LDS_n};
    end
  end

  assign as_s     = as_sync[1];
  assign ds_s     = ~uds_sync[1] | ~lds_sync[1];
  assign ack      = ac_dtack | dev_ready;
  assign z2_state = state;

`ifdef DTACK_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Counter is zero on the first Z2_DATA cycle and held at zero elsewhere.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n)
      tmo_cnt <= 8'd0;
    else if (state == Z2_DATA && state_nx == Z2_DATA)
      tmo_cnt <= tmo_cnt + 8'd1;
    else
      tmo_cnt <= 8'd0;
  end

  assign tmo_hit = (state == Z2_DATA) && (tmo_cnt == TIMEOUT_CYCLES - 8'd1);

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n)
      cycle_timeout <= 1'b0;
    else
      cycle_timeout <= tmo_fire;
  end
`else
  logic unused_cfg;

  assign tmo_hit       = 1'b0;
  assign cycle_timeout = 1'b0;
  assign unused_cfg    = ^{TIMEOUT_CYCLES, tmo_fire};
`endif

  // A cycle seen while unselected is ignored until AS_n rises again (skip).
  always_comb begin
    state_nx = state;
    skip_nx  = skip;
    tmo_fire = 1'b0;
    case (state)
      Z2_IDLE: begin
        if (as_s)
          skip_nx = 1'b0;
        else if (board_sel && !skip)
          state_nx = Z2_START;
        else
          skip_nx = 1'b1;
      end
      Z2_START: begin
        if (as_s)
          state_nx = Z2_IDLE;
        else if (ds_s)
          state_nx = Z2_DATA;
      end
      Z2_DATA: begin
        if (as_s)
          state_nx = Z2_IDLE;
        else if (ack)
          state_nx = Z2_END;
        else if (tmo_hit) begin
          state_nx = Z2_END;
          tmo_fire = 1'b1;
        end
      end
      Z2_END: begin
        if (as_s)
          state_nx = Z2_IDLE;
      end
      default: state_nx = Z2_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as z2_state.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state      <= Z2_IDLE;
      skip       <= 1'b0;
      rw_l       <= 1'b1;
      DTACK_n    <= 1'b1;
      dtack_oe   <= 1'b0;
      data_oe_n  <= 1'b1;
      data_latch <= 1'b0;
    end else begin
      state      <= state_nx;
      skip       <= skip_nx;
      if (state == Z2_IDLE && state_nx == Z2_START)
        rw_l <= RW;
      DTACK_n    <= (state_nx != Z2_END);
      // Leaving Z2_END keeps the driver on one more cycle to actively drive DTACK_n high.
      dtack_oe   <= (state_nx != Z2_IDLE) || (state == Z2_END);
      data_oe_n  <= !(rw_l && (state_nx == Z2_DATA || state_nx == Z2_END));
      data_latch <= !rw_l && (state == Z2_START) && (state_nx == Z2_DATA);
    end
  end

endmodule
